bcd_code_lock: RTL and testbench

- Keypad combination lock that sits directly downstream of the one-hot-to-BCD switch encoder.
- Consumes the encoder's 4-bit BCD digit plus a valid flag, where valid is the inverse of the encoder's idle flag.
- Debounces each press, collects CODE_LEN digits, compares them against a stored BCD code, and drives unlock, error and lockout indicators.
- last_digit is fed on to the 7-segment displayer.

---
 rtl/bcd_lock_pkg.sv | 20 ++
 rtl/digit_debouncer.sv | 57 +++++
 rtl/bcd_code_lock.sv | 168 ++++++++++++++++
 tb/tb_bcd_code_lock.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_lock_pkg.sv
// rtl/bcd_lock_pkg.sv - shared states and BCD constants for the keypad code lock
package bcd_lock_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    FAIL,
    LOCKOUT,
    PROG
  } lock_state_t;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/digit_debouncer.sv
// rtl/digit_debouncer.sv - press/release debouncer yielding one accept pulse per key press
module digit_debouncer
  import bcd_lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BCD_W-1:0] digit_in,
  input  logic             digit_valid,
  output logic             accept,
  output logic [BCD_W-1:0] digit_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic             released;
  logic [CW-1:0]    cnt;
  logic [BCD_W-1:0] held;
  logic             candidate;
  logic [CW-1:0]    run;

  assign candidate = digit_valid && is_bcd(digit_in);
  // a new or changed digit starts its own run from zero
  assign run       = (cnt != '0 && digit_in == held) ? cnt : '0;
  assign accept    = released && candidate && (run == LAST);
  assign digit_out = digit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      released <= 1'b1;
      cnt      <= '0;
      held     <= '0;
    end else if (released) begin
      if (!candidate) begin
        cnt <= '0;
      end else if (accept) begin
        released <= 1'b0;
        cnt      <= '0;
      end else begin
        cnt  <= run + 1'b1;
        held <= digit_in;
      end
    end else begin
      if (digit_valid) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        released <= 1'b1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_code_lock.sv
// rtl/bcd_code_lock.sv - BCD keypad combination lock; BCD_LOCK_PROGRAM_EN adds in-field code programming
module bcd_code_lock
  import bcd_lock_pkg::*;
#(
  parameter int CODE_LEN        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int UNLOCK_CYCLES   = 8,
  parameter int LOCKOUT_CYCLES  = 16,
  parameter int MAX_FAILS       = 3,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       clear,
`ifdef BCD_LOCK_PROGRAM_EN
  input  logic       program_en,
`endif
  output logic       unlocked,
  output logic       error,
  output logic       locked_out,
  output logic [3:0] digit_count,
  output logic [3:0] last_digit,
  output logic [2:0] fails
);

  localparam int CODE_W = BCD_W * CODE_LEN;
  localparam int T_MAX  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT       = TW'(T_MAX);
  localparam logic [3:0]    FINAL_IDX   = 4'(CODE_LEN - 1);

  lock_state_t       state, next_state;
  logic [CODE_W-1:0] entry_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] entry_shift;
  logic [TW-1:0]     timer;
  logic              accept;
  logic [BCD_W-1:0]  digit_db;
  logic              final_digit;

  digit_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .accept     (accept),
    .digit_out  (digit_db)
  );

  assign entry_shift = {entry_q[CODE_W-BCD_W-1:0], digit_db};
  assign final_digit = (digit_count == FINAL_IDX);

`ifdef BCD_LOCK_PROGRAM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= DEFAULT_CODE;
    end else if (state == PROG && !clear && accept && final_digit) begin
      code_q <= entry_shift;
    end
  end
`else
  assign code_q = DEFAULT_CODE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENTRY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ENTRY: begin
        if (!clear && accept && final_digit) next_state = CHECK;
      end
      CHECK: begin
        if (entry_q == code_q)                  next_state = OPEN;
        else if (fails + 3'd1 == 3'(MAX_FAILS)) next_state = LOCKOUT;
        else                                    next_state = FAIL;
      end
      OPEN: begin
        if (clear) next_state = ENTRY;
`ifdef BCD_LOCK_PROGRAM_EN
        else if (program_en) next_state = PROG;
`endif
        else if (timer == UNLOCK_LAST) next_state = ENTRY;
      end
      FAIL: next_state = ENTRY;
      LOCKOUT: begin
        if (timer == LOCK_LAST) next_state = ENTRY;
      end
`ifdef BCD_LOCK_PROGRAM_EN
      PROG: begin
        if (clear || (accept && final_digit)) next_state = ENTRY;
      end
`endif
      default: next_state = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q     <= '0;
      digit_count <= '0;
      last_digit  <= '0;
      fails       <= '0;
      timer       <= '0;
      unlocked    <= 1'b0;
      error       <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      // indicators follow the state being entered so they line up with it
      unlocked   <= (next_state == OPEN) || (next_state == PROG);
      error      <= (next_state == FAIL);
      locked_out <= (next_state == LOCKOUT);

      if (next_state != state) begin
        timer <= '0;
      end else if (state != PROG && timer != T_SAT) begin
        timer <= timer + 1'b1;
      end

      case (state)
        ENTRY: begin
          if (clear) begin
            digit_count <= '0;
            entry_q     <= '0;
          end else if (accept) begin
            entry_q     <= entry_shift;
            last_digit  <= digit_db;
            digit_count <= digit_count + 1'b1;
          end
        end
        CHECK: begin
          digit_count <= '0;
          entry_q     <= '0;
          if (next_state == OPEN) fails <= '0;
          else                    fails <= fails + 1'b1;
        end
        LOCKOUT: begin
          if (next_state == ENTRY) fails <= '0;
        end
`ifdef BCD_LOCK_PROGRAM_EN
        PROG: begin
          if (clear || (accept && final_digit)) begin
            digit_count <= '0;
            entry_q     <= '0;
          end else if (accept) begin
            entry_q     <= entry_shift;
            digit_count <= digit_count + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_code_lock.sv
// tb/tb_bcd_code_lock.sv - self-checking bench: vector table, corner sequences, random presses vs model
module tb_bcd_code_lock;

  localparam int CL = 4;
  localparam int DB = 4;
  localparam int UC = 8;
  localparam int LC = 16;
  localparam int MF = 3;

  localparam int M_ENTRY = 0;
  localparam int M_CHECK = 1;
  localparam int M_OPEN  = 2;
  localparam int M_ERR   = 3;
  localparam int M_LOCK  = 4;
  localparam int M_PROG  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic       program_en;
  logic       unlocked, error, locked_out;
  logic [3:0] digit_count, last_digit;
  logic [2:0] fails;

  int checks   = 0;
  int failures = 0;
  int hi_unl, hi_err, hi_lock;

  always #5 clk = ~clk;

  bcd_code_lock #(
    .CODE_LEN(CL), .DEBOUNCE_CYCLES(DB), .UNLOCK_CYCLES(UC),
    .LOCKOUT_CYCLES(LC), .MAX_FAILS(MF), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear),
`ifdef BCD_LOCK_PROGRAM_EN
    .program_en(program_en),
`endif
    .unlocked(unlocked), .error(error), .locked_out(locked_out),
    .digit_count(digit_count), .last_digit(last_digit), .fails(fails)
  );

  // reference model: press history window plus a phase/countdown view of the lock
  int         m_phase, m_left, m_last, m_fails;
  int         m_ent[$];
  int         m_code[CL];
  bit         m_armed;
  int         m_since;
  logic [4:0] m_hist[$];

  task automatic m_reset();
    m_phase = M_ENTRY; m_left = 0; m_last = 0; m_fails = 0;
    m_ent.delete(); m_hist.delete();
    m_armed = 1'b1; m_since = 0;
    m_code = '{1, 2, 3, 4};
  endtask

  function automatic bit window_all(input bit want_press);
    logic [4:0] h, first;
    if (m_hist.size() < DB) return 1'b0;
    first = m_hist[0];
    for (int i = 0; i < DB; i++) begin
      h = m_hist[i];
      if (want_press) begin
        if (!h[4] || h[3:0] > 4'd9 || h[3:0] != first[3:0]) return 1'b0;
      end else if (h[4]) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic m_lock_step(input bit acc, input int d);
    bit match;
    case (m_phase)
      M_ENTRY: begin
        if (clear) m_ent.delete();
        else if (acc) begin
          m_ent.push_back(d); m_last = d;
          if (m_ent.size() == CL) m_phase = M_CHECK;
        end
      end
      M_CHECK: begin
        match = 1'b1;
        for (int i = 0; i < CL; i++) if (m_ent[i] != m_code[i]) match = 1'b0;
        m_ent.delete();
        if (match) begin
          m_phase = M_OPEN; m_left = UC; m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MF) begin m_phase = M_LOCK; m_left = LC; end
          else m_phase = M_ERR;
        end
      end
      M_OPEN: begin
        if (clear) m_phase = M_ENTRY;
        else if (program_en) m_phase = M_PROG;
        else begin
          m_left--;
          if (m_left == 0) m_phase = M_ENTRY;
        end
      end
      M_ERR: m_phase = M_ENTRY;
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_phase = M_ENTRY; m_fails = 0; end
      end
      M_PROG: begin
        if (clear) begin m_ent.delete(); m_phase = M_ENTRY; end
        else if (acc) begin
          m_ent.push_back(d);
          if (m_ent.size() == CL) begin
            for (int i = 0; i < CL; i++) m_code[i] = m_ent[i];
            m_ent.delete(); m_phase = M_ENTRY;
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      m_reset();
    end else begin
      m_hist.push_back({digit_valid, digit_in});
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      m_since++;
      acc = 1'b0;
      if (m_since >= DB) begin
        if (m_armed && window_all(1'b1)) begin acc = 1'b1; m_armed = 1'b0; m_since = 0; end
        else if (!m_armed && window_all(1'b0)) begin m_armed = 1'b1; m_since = 0; end
      end
      m_lock_step(acc, int'(digit_in));
    end
  end

  function automatic logic [13:0] m_expect();
    logic [3:0] c, l;
    logic [2:0] f;
    c = 4'(m_ent.size()); l = 4'(m_last); f = 3'(m_fails);
    return {m_phase == M_OPEN || m_phase == M_PROG, m_phase == M_ERR, m_phase == M_LOCK, c, l, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [3:0] d, input logic c);
    digit_valid = v; digit_in = d; clear = c;
    @(negedge clk);
    chk("cycle_vs_model",
        32'({unlocked, error, locked_out, digit_count, last_digit, fails}), 32'(m_expect()));
    if (unlocked)   hi_unl++;
    if (error)      hi_err++;
    if (locked_out) hi_lock++;
  endtask

  task automatic press(input logic v, input logic [3:0] d, input int hold, input int rel, input logic c);
    repeat (hold) cyc(v, d, 1'b0);
    repeat (rel) cyc(1'b0, 4'd0, c);
  endtask

  task automatic enter4(input logic [15:0] code);
    for (int i = 0; i < 4; i++) press(1'b1, code[15-4*i -: 4], 4, 4, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1'b0, 4'd0, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       vld;
    logic [3:0] dig;
    int         hold;
    int         rel;
    logic       clr;
    logic [3:0] e_cnt;
    logic [3:0] e_last;
    logic [2:0] e_fails;
    logic       e_unl;
    logic       e_lock;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic v, input logic [3:0] d, input int h, input int r, input logic c,
                     input logic [3:0] ec, input logic [3:0] el, input logic [2:0] ef,
                     input logic eu, input logic elk);
    vec_t e;
    e.vld = v; e.dig = d; e.hold = h; e.rel = r; e.clr = c;
    e.e_cnt = ec; e.e_last = el; e.e_fails = ef; e.e_unl = eu; e.e_lock = elk;
    tab.push_back(e);
  endtask

  initial begin
    int code_idx;
    logic [15:0] seq;
    logic [3:0] d;
    reset = 1'b1; digit_valid = 1'b0; digit_in = 4'd0; clear = 1'b0; program_en = 1'b0;
    hi_unl = 0; hi_err = 0; hi_lock = 0;
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    chk("reset_outputs", 32'({unlocked, error, locked_out, digit_count, last_digit, fails}), 32'd0);

    // correct code, idle, held key, clear, invalid digit, clear mid-entry
    add(1, 4'd1, 4, 4, 0, 4'd1, 4'd1, 3'd0, 0, 0);
    add(1, 4'd2, 4, 4, 0, 4'd2, 4'd2, 3'd0, 0, 0);
    add(1, 4'd3, 4, 4, 0, 4'd3, 4'd3, 3'd0, 0, 0);
    add(1, 4'd4, 4, 4, 0, 4'd0, 4'd4, 3'd0, 1, 0);
    add(0, 4'd0, 0, 8, 0, 4'd0, 4'd4, 3'd0, 0, 0);
    add(1, 4'd7, 20, 4, 0, 4'd1, 4'd7, 3'd0, 0, 0);
    add(0, 4'd0, 0, 1, 1, 4'd0, 4'd7, 3'd0, 0, 0);
    add(1, 4'hC, 10, 4, 0, 4'd0, 4'd7, 3'd0, 0, 0);
    add(1, 4'd1, 4, 4, 0, 4'd1, 4'd1, 3'd0, 0, 0);
    add(1, 4'd2, 4, 4, 0, 4'd2, 4'd2, 3'd0, 0, 0);
    add(0, 4'd0, 0, 1, 1, 4'd0, 4'd2, 3'd0, 0, 0);
    add(1, 4'd1, 4, 4, 0, 4'd1, 4'd1, 3'd0, 0, 0);
    add(1, 4'd2, 4, 4, 0, 4'd2, 4'd2, 3'd0, 0, 0);
    add(1, 4'd3, 4, 4, 0, 4'd3, 4'd3, 3'd0, 0, 0);
    add(1, 4'd4, 4, 4, 0, 4'd0, 4'd4, 3'd0, 1, 0);
    add(0, 4'd0, 0, 8, 0, 4'd0, 4'd4, 3'd0, 0, 0);
    for (int a = 1; a <= 3; a++) begin
      add(1, 4'd1, 4, 4, 0, 4'd1, 4'd1, 3'(a-1), 0, 0);
      add(1, 4'd2, 4, 4, 0, 4'd2, 4'd2, 3'(a-1), 0, 0);
      add(1, 4'd3, 4, 4, 0, 4'd3, 4'd3, 3'(a-1), 0, 0);
      add(1, 4'd5, 4, 4, 0, 4'd0, 4'd5, 3'(a), 0, a == 3);
    end
    add(1, 4'd1, 4, 4, 0, 4'd0, 4'd5, 3'd3, 0, 1);
    add(0, 4'd0, 0, 8, 0, 4'd0, 4'd5, 3'd0, 0, 0);
    add(1, 4'd1, 4, 4, 0, 4'd1, 4'd1, 3'd0, 0, 0);
    add(1, 4'd2, 4, 4, 0, 4'd2, 4'd2, 3'd0, 0, 0);
    add(1, 4'd3, 4, 4, 0, 4'd3, 4'd3, 3'd0, 0, 0);
    add(1, 4'd4, 4, 4, 0, 4'd0, 4'd4, 3'd0, 1, 0);
    add(0, 4'd0, 0, 8, 0, 4'd0, 4'd4, 3'd0, 0, 0);

    for (int i = 0; i < tab.size(); i++) begin
      press(tab[i].vld, tab[i].dig, tab[i].hold, tab[i].rel, tab[i].clr);
      chk($sformatf("vec%0d", i),
          32'({digit_count, last_digit, fails, unlocked, locked_out}),
          32'({tab[i].e_cnt, tab[i].e_last, tab[i].e_fails, tab[i].e_unl, tab[i].e_lock}));
    end

    // unlock window length
    hi_unl = 0;
    enter4(16'h1234);
    repeat (10) cyc(1'b0, 4'd0, 1'b0);
    chk("unlock_cycles", 32'(hi_unl), 32'd8);

    // glitching valid never debounces
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 4'd7, 1'b0); cyc(1'b1, 4'd7, 1'b0); cyc(1'b0, 4'd0, 1'b0);
    end
    repeat (4) cyc(1'b0, 4'd0, 1'b0);
    chk("glitch_count", 32'(digit_count), 32'd0);

    // error pulses, lockout duration, digits ignored during lockout
    hi_err = 0; hi_lock = 0;
    repeat (3) enter4(16'h1235);
    press(1'b1, 4'd9, 4, 4, 1'b0);
    press(1'b1, 4'd8, 4, 4, 1'b1);
    chk("lockout_ignores", 32'({digit_count, last_digit}), 32'({4'd0, 4'd5}));
    repeat (20) cyc(1'b0, 4'd0, 1'b0);
    chk("error_pulses", 32'(hi_err), 32'd2);
    chk("lockout_cycles", 32'(hi_lock), 32'd16);
    chk("fails_after_lockout", 32'(fails), 32'd0);

    // reset on the third OPEN cycle
    for (int i = 0; i < 3; i++) press(1'b1, 4'(i+1), 4, 4, 1'b0);
    repeat (4) cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    chk("open_before_reset", 32'(unlocked), 32'd1);
    pulse_reset();
    chk("reset_in_open", 32'({unlocked, error, locked_out, digit_count, last_digit, fails}), 32'd0);
    enter4(16'h1234);
    chk("unlock_after_reset", 32'(unlocked), 32'd1);
    repeat (8) cyc(1'b0, 4'd0, 1'b0);

    // reset during lockout
    repeat (3) enter4(16'h9999);
    repeat (3) cyc(1'b0, 4'd0, 1'b0);
    chk("in_lockout", 32'(locked_out), 32'd1);
    pulse_reset();
    chk("reset_in_lockout", 32'({unlocked, error, locked_out, digit_count, last_digit, fails}), 32'd0);
    enter4(16'h1234);
    chk("unlock_after_lock_reset", 32'(unlocked), 32'd1);
    repeat (8) cyc(1'b0, 4'd0, 1'b0);

`ifdef BCD_LOCK_PROGRAM_EN
    for (int i = 0; i < 3; i++) press(1'b1, 4'(i+1), 4, 4, 1'b0);
    repeat (4) cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
    program_en = 1'b1;
    cyc(1'b0, 4'd0, 1'b0);
    program_en = 1'b0;
    repeat (3) cyc(1'b0, 4'd0, 1'b0);
    chk("prog_unlocked", 32'(unlocked), 32'd1);
    enter4(16'h9876);
    chk("prog_done", 32'(unlocked), 32'd0);
    hi_err = 0;
    enter4(16'h1234);
    chk("old_code_rejected", 32'(hi_err), 32'd1);
    enter4(16'h9876);
    chk("new_code_accepted", 32'(unlocked), 32'd1);
    repeat (8) cyc(1'b0, 4'd0, 1'b0);
    pulse_reset();
`endif

    // random presses, mostly walking the stored code, checked every cycle by the model
    seq = 16'h1234;
    code_idx = 0;
    for (int a = 0; a < 250; a++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        pulse_reset();
      end else if (r < 6) begin
        cyc(1'b0, 4'd0, 1'b1);
      end else begin
        if ($urandom_range(0, 3) != 0) begin
          d = seq[15-4*code_idx -: 4];
          code_idx = (code_idx + 1) % 4;
        end else begin
          d = 4'($urandom_range(0, 15));
        end
        repeat ($urandom_range(1, 7)) cyc($urandom_range(0, 9) != 0, d, 1'b0);
        repeat ($urandom_range(1, 7)) begin
          if ($urandom_range(0, 9) == 0) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0);
          else cyc(1'b0, 4'd0, 1'b0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
